// File: rtl/apb_mtimer.sv
// apb_mtimer -- RISC-V style machine timer behind an APB slave port.
//
// Purpose: holds a free-running 64-bit mtime counter (advanced once every
// TICK_DIV clocks by a prescaler) and a 64-bit mtimecmp register, and raises
// the level interrupt mtip whenever mtime >= mtimecmp. Both registers are
// readable and byte-writable over APB with exactly one wait state per access.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   t_psel      APB select
//   t_penable   APB access phase
//   t_pready    APB ready (high only in the completing cycle)
//   t_paddr     APB byte address (MTIMER_ADDR_W bits)
//   t_pwrite    1 = write, 0 = read
//   t_pwdata    write data
//   t_pwstrb    byte write strobes
//   t_prdata    read data (zero unless a legal read completes)
//   t_pslverr   APB error (bad address or misaligned access)
//   mtip        machine timer interrupt pending, registered level
//
// Register map: 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32],
//               0xBFF8 mtime[31:0],    0xBFFC mtime[63:32].

module apb_mtimer #(
  parameter int MTIMER_ADDR_W = 16,
  parameter int TICK_DIV      = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     t_psel,
  input  logic                     t_penable,
  output logic                     t_pready,
  input  logic [MTIMER_ADDR_W-1:0] t_paddr,
  input  logic                     t_pwrite,
  input  logic [31:0]              t_pwdata,
  input  logic [3:0]               t_pwstrb,
  output logic [31:0]              t_prdata,
  output logic                     t_pslverr,
  output logic                     mtip
);

  // ACC_WAIT doubles as the idle state; ACC_DONE is the completing cycle.
  typedef enum logic {ACC_WAIT = 1'b0, ACC_DONE = 1'b1} accState_e;

  localparam logic [MTIMER_ADDR_W-1:0] ADDR_CMP_LO  = MTIMER_ADDR_W'(16'h4000);
  localparam logic [MTIMER_ADDR_W-1:0] ADDR_CMP_HI  = MTIMER_ADDR_W'(16'h4004);
  localparam logic [MTIMER_ADDR_W-1:0] ADDR_TIME_LO = MTIMER_ADDR_W'(16'hBFF8);
  localparam logic [MTIMER_ADDR_W-1:0] ADDR_TIME_HI = MTIMER_ADDR_W'(16'hBFFC);
  localparam logic [15:0]              PRESC_LAST   = 16'(TICK_DIV - 1);

  accState_e   state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimeCmp_q, mtimeCmp_d;
  logic [15:0] prescaler_q, prescaler_d;
  logic        mtip_q, mtip_d;

  logic        selCmpLo, selCmpHi, selTimeLo, selTimeHi, addrErr;
  logic        accessPhase, complete, wrEn, timeWr, tick;
  logic [31:0] readWord;

  // Replace only the strobed bytes of a 32-bit word.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  strb);
    logic [31:0] result;
    result = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) result[8*b +: 8] = newWord[8*b +: 8];
    end
    return result;
  endfunction

  // Address decode. Exact matches only, so any misaligned address
  // (paddr[1:0] != 0) falls out as an error automatically.
  always_comb begin
    selCmpLo    = (t_paddr == ADDR_CMP_LO);
    selCmpHi    = (t_paddr == ADDR_CMP_HI);
    selTimeLo   = (t_paddr == ADDR_TIME_LO);
    selTimeHi   = (t_paddr == ADDR_TIME_HI);
    addrErr     = ~(selCmpLo | selCmpHi | selTimeLo | selTimeHi);
    accessPhase = t_psel & t_penable;
    readWord    = 32'h0;
    if (selCmpLo)       readWord = mtimeCmp_q[31:0];
    else if (selCmpHi)  readWord = mtimeCmp_q[63:32];
    else if (selTimeLo) readWord = mtime_q[31:0];
    else if (selTimeHi) readWord = mtime_q[63:32];
  end

  // Transfer FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACC_WAIT;
    else     state_q <= state_d;
  end

  // Transfer FSM: next state. The first access-phase cycle is the wait
  // state; the following cycle always completes and falls back to ACC_WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC_WAIT: if (accessPhase) state_d = ACC_DONE;
      ACC_DONE: state_d = ACC_WAIT;
      default:  state_d = ACC_WAIT;
    endcase
  end

  // Transfer FSM: outputs. Reset masks pready so a transfer caught by
  // reset in its completing cycle is abandoned without a response.
  always_comb begin
    t_pready  = (state_q == ACC_DONE) & ~rst;
    complete  = t_pready & accessPhase;
    t_pslverr = 1'b0;
    t_prdata  = 32'h0;
    if (t_pready) begin
      if (addrErr)        t_pslverr = 1'b1;
      else if (!t_pwrite) t_prdata  = readWord;
    end
  end

  // Prescaler, mtime and mtimecmp next state. An mtime write with at least
  // one strobe replaces the increment for that cycle; a zero-strobe write
  // leaves the counter running normally.
  always_comb begin
    wrEn   = complete & t_pwrite & ~addrErr;
    timeWr = wrEn & (selTimeLo | selTimeHi) & (|t_pwstrb);
    tick   = (prescaler_q == PRESC_LAST);

    prescaler_d = tick ? 16'd0 : prescaler_q + 16'd1;

    mtime_d = mtime_q;
    if (timeWr) begin
      if (selTimeLo) mtime_d[31:0]  = mergeBytes(mtime_q[31:0], t_pwdata, t_pwstrb);
      if (selTimeHi) mtime_d[63:32] = mergeBytes(mtime_q[63:32], t_pwdata, t_pwstrb);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    mtimeCmp_d = mtimeCmp_q;
    if (wrEn & selCmpLo) mtimeCmp_d[31:0]  = mergeBytes(mtimeCmp_q[31:0], t_pwdata, t_pwstrb);
    if (wrEn & selCmpHi) mtimeCmp_d[63:32] = mergeBytes(mtimeCmp_q[63:32], t_pwdata, t_pwstrb);

    // Compare current register contents; the result appears one cycle later.
    mtip_d = (mtime_q >= mtimeCmp_q);
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= 64'h0;
      mtimeCmp_q  <= '1;
      prescaler_q <= 16'd0;
      mtip_q      <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimeCmp_q  <= mtimeCmp_d;
      prescaler_q <= prescaler_d;
      mtip_q      <= mtip_d;
    end
  end

  assign mtip = mtip_q;

endmodule

// File: tb/tb_apb_mtimer.sv
// tb_apb_mtimer -- drives two apb_mtimer instances (TICK_DIV=1 and TICK_DIV=4)
// with identical APB traffic and compares them against a cycle-level
// behavioural model of the timer kept in this file.

module tb_apb_mtimer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic [1:0]  pready, pslverr, mtip;
  logic [1:0][31:0] prdata;

  apb_mtimer #(.MTIMER_ADDR_W(16), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .t_psel(psel), .t_penable(penable), .t_pready(pready[0]),
    .t_paddr(paddr), .t_pwrite(pwrite), .t_pwdata(pwdata), .t_pwstrb(pwstrb),
    .t_prdata(prdata[0]), .t_pslverr(pslverr[0]), .mtip(mtip[0]));

  apb_mtimer #(.MTIMER_ADDR_W(16), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .t_psel(psel), .t_penable(penable), .t_pready(pready[1]),
    .t_paddr(paddr), .t_pwrite(pwrite), .t_pwdata(pwdata), .t_pwstrb(pwstrb),
    .t_prdata(prdata[1]), .t_pslverr(pslverr[1]), .mtip(mtip[1]));

  int passCount  = 0;
  int checkCount = 0;

  // Behavioural model: index 0 models TICK_DIV=1, index 1 models TICK_DIV=4.
  logic [63:0] mMtime [2];
  logic [63:0] mCmp   [2];
  int unsigned mCyc   [2];
  logic        mMtip  [2];
  bit          compCycle;

  // Observations captured by applyStimulus, plus the model's expectation.
  logic [1:0]       oSetupRdy, oWaitRdy, oWaitErr, oDoneRdy, oDoneErr, oDoneMtip;
  logic [1:0][31:0] oWaitData, oDoneData, eDoneData;
  logic [1:0]       eDoneErr, eDoneMtip;
  logic [63:0]      eDoneMtime [2];

  function automatic int unsigned divOf(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic bit legalAddr(input logic [15:0] a);
    return (a == 16'h4000) || (a == 16'h4004) || (a == 16'hBFF8) || (a == 16'hBFFC);
  endfunction

  function automatic logic [31:0] mergeWord(input logic [31:0] o, input logic [31:0] d,
                                            input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelWord(input int k, input logic [15:0] a);
    case (a)
      16'h4000: return mCmp[k][31:0];
      16'h4004: return mCmp[k][63:32];
      16'hBFF8: return mMtime[k][31:0];
      16'hBFFC: return mMtime[k][63:32];
      default:  return 32'h0;
    endcase
  endfunction

  function automatic bit modelWrite();
    return compCycle && pwrite && legalAddr(paddr) && (pwstrb != 4'b0000);
  endfunction

  function automatic logic [63:0] modelNextMtime(input int k);
    logic [63:0] t;
    t = mMtime[k];
    if (modelWrite() && paddr == 16'hBFF8) return {t[63:32], mergeWord(t[31:0], pwdata, pwstrb)};
    if (modelWrite() && paddr == 16'hBFFC) return {mergeWord(t[63:32], pwdata, pwstrb), t[31:0]};
    if ((mCyc[k] % divOf(k)) == divOf(k) - 1) return t + 64'd1;
    return t;
  endfunction

  function automatic logic [63:0] modelNextCmp(input int k);
    logic [63:0] c;
    c = mCmp[k];
    if (modelWrite() && paddr == 16'h4000) return {c[63:32], mergeWord(c[31:0], pwdata, pwstrb)};
    if (modelWrite() && paddr == 16'h4004) return {mergeWord(c[63:32], pwdata, pwstrb), c[31:0]};
    return c;
  endfunction

  // Model update at every rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mMtime[k] <= 64'h0;
        mCmp[k]   <= '1;
        mCyc[k]   <= 0;
        mMtip[k]  <= 1'b0;
      end else begin
        mCyc[k]   <= mCyc[k] + 1;
        mMtip[k]  <= (mMtime[k] >= mCmp[k]);
        mMtime[k] <= modelNextMtime(k);
        mCmp[k]   <= modelNextCmp(k);
      end
    end
  end

  // One complete APB transfer. Called #1 after a rising edge; returns #1
  // after the edge that ends the completing cycle, bus idle.
  task automatic applyStimulus(input logic [15:0] a, input logic w,
                               input logic [31:0] d, input logic [3:0] s);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pwstrb = s;
    @(negedge clk);
    oSetupRdy = pready;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    oWaitRdy = pready; oWaitErr = pslverr; oWaitData = prdata;
    @(posedge clk); #1 compCycle = 1'b1;
    @(negedge clk);
    oDoneRdy = pready; oDoneErr = pslverr; oDoneData = prdata; oDoneMtip = mtip;
    for (int k = 0; k < 2; k++) begin
      eDoneErr[k]   = !legalAddr(a);
      eDoneData[k]  = (!legalAddr(a) || w) ? 32'h0 : modelWord(k, a);
      eDoneMtip[k]  = mMtip[k];
      eDoneMtime[k] = mMtime[k];
    end
    @(posedge clk); #1;
    compCycle = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h4000; pwdata = 32'h0; pwstrb = 4'hF;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checkCount++; if (pready[k] !== 1'b0) $display("[TB] FAIL rst_pready dut%0d got %b exp 0", k, pready[k]); else passCount++;
        checkCount++; if (pslverr[k] !== 1'b0) $display("[TB] FAIL rst_pslverr dut%0d got %b exp 0", k, pslverr[k]); else passCount++;
        checkCount++; if (prdata[k] !== 32'h0) $display("[TB] FAIL rst_prdata dut%0d got %h exp 0", k, prdata[k]); else passCount++;
        checkCount++; if (mtip[k] !== 1'b0) $display("[TB] FAIL rst_mtip dut%0d got %b exp 0", k, mtip[k]); else passCount++;
      end
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst = 1'b0;
  endtask

  task automatic test_basic_read();
    logic [31:0] expLo [2];
    expLo[0] = 32'd2; expLo[1] = 32'd0;
    applyStimulus(16'hBFF8, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      checkCount++; if (oSetupRdy[k] !== 1'b0) $display("[TB] FAIL setup_pready dut%0d got %b exp 0", k, oSetupRdy[k]); else passCount++;
      checkCount++; if (oWaitRdy[k] !== 1'b0) $display("[TB] FAIL wait_pready dut%0d got %b exp 0", k, oWaitRdy[k]); else passCount++;
      checkCount++; if (oWaitErr[k] !== 1'b0 || oWaitData[k] !== 32'h0) $display("[TB] FAIL wait_resp dut%0d got err %b data %h exp 0/0", k, oWaitErr[k], oWaitData[k]); else passCount++;
      checkCount++; if (oDoneRdy[k] !== 1'b1) $display("[TB] FAIL done_pready dut%0d got %b exp 1", k, oDoneRdy[k]); else passCount++;
      checkCount++; if (oDoneErr[k] !== 1'b0) $display("[TB] FAIL read_pslverr dut%0d got %b exp 0", k, oDoneErr[k]); else passCount++;
      checkCount++; if (oDoneData[k] !== expLo[k]) $display("[TB] FAIL elapsed_mtime dut%0d got %h exp %h", k, oDoneData[k], expLo[k]); else passCount++;
      checkCount++; if (oDoneData[k] !== eDoneData[k]) $display("[TB] FAIL model_mtime_lo dut%0d got %h exp %h", k, oDoneData[k], eDoneData[k]); else passCount++;
    end
    applyStimulus(16'hBFFC, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      checkCount++; if (oDoneData[k] !== 32'h0) $display("[TB] FAIL mtime_hi dut%0d got %h exp 0", k, oDoneData[k]); else passCount++;
    end
  endtask

  task automatic test_mtip();
    int i;
    applyStimulus(16'h4004, 1'b1, 32'h0, 4'hF);
    applyStimulus(16'h4000, 1'b1, 32'h20, 4'hF);
    i = 0;
    while (i < 400 && mMtime[1] < 64'h24) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checkCount++; if (mtip[k] !== mMtip[k]) $display("[TB] FAIL mtip_rise dut%0d got %b exp %b", k, mtip[k], mMtip[k]); else passCount++;
      end
      if (mMtime[0] == 64'h20) begin
        checkCount++; if (mtip[0] !== 1'b0) $display("[TB] FAIL mtip_at_0x20 got %b exp 0", mtip[0]); else passCount++;
      end
      if (mMtime[0] == 64'h21) begin
        checkCount++; if (mtip[0] !== 1'b1) $display("[TB] FAIL mtip_after_0x20 got %b exp 1", mtip[0]); else passCount++;
      end
      @(posedge clk); #1;
      i++;
    end
    checkCount++; if (mMtime[1] < 64'h24) $display("[TB] FAIL mtip_timeout got %h exp >= 24", mMtime[1]); else passCount++;
    applyStimulus(16'h4000, 1'b1, 32'hFFFF_FFFF, 4'hF);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checkCount++; if (mtip[k] !== ((c == 0) ? 1'b1 : 1'b0)) $display("[TB] FAIL mtip_clear dut%0d cyc %0d got %b exp %b", k, c, mtip[k], (c == 0)); else passCount++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    applyStimulus(16'h4004, 1'b1, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(16'hBFFC, 1'b1, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(16'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checkCount++; if (mtip[k] !== mMtip[k]) $display("[TB] FAIL wrap_mtip dut%0d cyc %0d got %b exp %b", k, c, mtip[k], mMtip[k]); else passCount++;
      end
      if (c < 3) begin
        checkCount++; if (mtip[0] !== (c == 1)) $display("[TB] FAIL wrap_mtip_pulse cyc %0d got %b exp %b", c, mtip[0], (c == 1)); else passCount++;
      end
      @(posedge clk); #1;
    end
    applyStimulus(16'hBFFC, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      checkCount++; if (oDoneData[k] !== 32'h0) $display("[TB] FAIL wrap_hi dut%0d got %h exp 0", k, oDoneData[k]); else passCount++;
    end
    applyStimulus(16'hBFF8, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      checkCount++; if (oDoneData[k] !== eDoneData[k]) $display("[TB] FAIL wrap_lo dut%0d got %h exp %h", k, oDoneData[k], eDoneData[k]); else passCount++;
    end
  endtask

  task automatic test_strobe_tick();
    logic [31:0] snapLo, expLo;
    applyStimulus(16'hBFF8, 1'b1, 32'h0000_AB00, 4'b0010);
    snapLo = eDoneMtime[0][31:0];
    expLo  = ((snapLo & 32'hFFFF_00FF) | 32'h0000_AB00) + 32'd2;
    applyStimulus(16'hBFF8, 1'b0, 32'h0, 4'h0);
    checkCount++; if (oDoneData[0] !== expLo) $display("[TB] FAIL strobe_byte1 dut0 got %h exp %h", oDoneData[0], expLo); else passCount++;
    for (int k = 0; k < 2; k++) begin
      checkCount++; if (oDoneData[k] !== eDoneData[k]) $display("[TB] FAIL strobe_model dut%0d got %h exp %h", k, oDoneData[k], eDoneData[k]); else passCount++;
    end
  endtask

  task automatic test_errors();
    logic [15:0] addrs [5];
    logic [15:0] a;
    addrs[0] = 16'h0000; addrs[1] = 16'h4002;
    for (int j = 2; j < 5; j++) begin
      do a = 16'($urandom); while (legalAddr(a));
      addrs[j] = a;
    end
    for (int j = 0; j < 10; j++) begin
      applyStimulus(addrs[j % 5], (j >= 5), 32'($urandom), 4'hF);
      for (int k = 0; k < 2; k++) begin
        checkCount++; if (oDoneRdy[k] !== 1'b1) $display("[TB] FAIL err_pready dut%0d got %b exp 1", k, oDoneRdy[k]); else passCount++;
        checkCount++; if (oDoneErr[k] !== 1'b1) $display("[TB] FAIL err_pslverr dut%0d addr %h got %b exp 1", k, addrs[j % 5], oDoneErr[k]); else passCount++;
        checkCount++; if (oDoneData[k] !== 32'h0) $display("[TB] FAIL err_prdata dut%0d got %h exp 0", k, oDoneData[k]); else passCount++;
      end
    end
    applyStimulus(16'h4000, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      checkCount++; if (oDoneData[k] !== 32'hFFFF_FFFF) $display("[TB] FAIL err_cmp_lo dut%0d got %h exp ffffffff", k, oDoneData[k]); else passCount++;
    end
    applyStimulus(16'h4004, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      checkCount++; if (oDoneData[k] !== 32'hFFFF_FFFF) $display("[TB] FAIL err_cmp_hi dut%0d got %h exp ffffffff", k, oDoneData[k]); else passCount++;
    end
  endtask

  task automatic test_random();
    logic [15:0] legal [4];
    logic [15:0] a;
    int r;
    legal[0] = 16'h4000; legal[1] = 16'h4004; legal[2] = 16'hBFF8; legal[3] = 16'hBFFC;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8) a = legal[r % 4];
      else do a = 16'($urandom); while (legalAddr(a));
      applyStimulus(a, 1'($urandom_range(0, 1)), 32'($urandom), 4'($urandom_range(0, 15)));
      for (int k = 0; k < 2; k++) begin
        checkCount++; if (oDoneRdy[k] !== 1'b1) $display("[TB] FAIL rnd_pready dut%0d got %b exp 1", k, oDoneRdy[k]); else passCount++;
        checkCount++; if (oDoneErr[k] !== eDoneErr[k]) $display("[TB] FAIL rnd_pslverr dut%0d addr %h got %b exp %b", k, a, oDoneErr[k], eDoneErr[k]); else passCount++;
        checkCount++; if (oDoneData[k] !== eDoneData[k]) $display("[TB] FAIL rnd_prdata dut%0d addr %h got %h exp %h", k, a, oDoneData[k], eDoneData[k]); else passCount++;
        checkCount++; if (oDoneMtip[k] !== eDoneMtip[k]) $display("[TB] FAIL rnd_mtip dut%0d got %b exp %b", k, oDoneMtip[k], eDoneMtip[k]); else passCount++;
      end
    end
  endtask

  task automatic test_reset_midxfer();
    logic [31:0] exp1 [3];
    logic [31:0] exp4 [3];
    exp1[0] = 32'd2; exp1[1] = 32'd5; exp1[2] = 32'd8;
    exp4[0] = 32'd0; exp4[1] = 32'd1; exp4[2] = 32'd2;
    psel = 1'b1; penable = 1'b0; paddr = 16'hBFF8; pwrite = 1'b1; pwdata = 32'h1234_5678; pwstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkCount++; if (pready[k] !== 1'b0) $display("[TB] FAIL abort_wait_pready dut%0d got %b exp 0", k, pready[k]); else passCount++;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checkCount++; if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 || prdata[k] !== 32'h0) $display("[TB] FAIL abort_resp dut%0d got rdy %b err %b data %h exp 0/0/0", k, pready[k], pslverr[k], prdata[k]); else passCount++;
    end
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    for (int j = 0; j < 3; j++) begin
      applyStimulus(16'hBFF8, 1'b0, 32'h0, 4'h0);
      if (j == 0) begin
        for (int k = 0; k < 2; k++) begin
          checkCount++; if (oSetupRdy[k] !== 1'b0) $display("[TB] FAIL abort_late_pready dut%0d got %b exp 0", k, oSetupRdy[k]); else passCount++;
        end
      end
      checkCount++; if (oDoneData[0] !== exp1[j]) $display("[TB] FAIL post_rst_mtime dut0 read %0d got %h exp %h", j, oDoneData[0], exp1[j]); else passCount++;
      checkCount++; if (oDoneData[1] !== exp4[j]) $display("[TB] FAIL post_rst_mtime dut1 read %0d got %h exp %h", j, oDoneData[1], exp4[j]); else passCount++;
    end
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 16'h0; pwdata = 32'h0; pwstrb = 4'h0; compCycle = 1'b0;
    test_reset();
    test_basic_read();
    test_mtip();
    test_wrap();
    test_strobe_tick();
    test_errors();
    test_random();
    test_reset_midxfer();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after %0d checks", checkCount);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/apb_mtimer.md
APB_MTIMER -- requirements
Module: apb_mtimer

Interface
REQ-001 Parameters SHALL be: MTIMER_ADDR_W, 16, APB address width; TICK_DIV, 1, clk cycles per mtime increment (legal range 1..65535).
REQ-002 Clocking and reset SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
 clk  in  1  clock; all state changes on rising edge
 rst  in  1  synchronous active-high reset
 t_psel  in  1  APB select
 t_penable  in  1  APB access phase
 t_pready  out  1  APB ready
 t_paddr  in  MTIMER_ADDR_W  byte address
 t_pwrite  in  1  1=write, 0=read
 t_pwdata  in  32  write data
 t_pwstrb  in  4  byte write strobes
 t_prdata  out  32  read data
 t_pslverr  out  1  APB error
 mtip  out  1  machine timer interrupt pending, level

Function
REQ-004 The register map SHALL be: 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-005 The block SHALL insert exactly one wait state: the first access-phase cycle (psel&penable) drives pready=0, the second drives pready=1, and the transfer completes there.
REQ-006 pready SHALL be 0 in every cycle that is not the completing cycle, including setup phase and idle.
REQ-007 A two-state FSM SHALL track each transfer: ACC_WAIT (set on psel&penable&~pready) -> ACC_DONE (pready=1, return to ACC_WAIT if the next cycle is a fresh access, else idle).
REQ-008 An access SHALL be an error when the address is not one of the four REQ-004 addresses or when paddr[1:0]!=0.
REQ-009 On an erroring transfer the block SHALL drive pslverr=1 and prdata=0 in the completing cycle and SHALL leave all registers unchanged.
REQ-010 On a non-error read, prdata SHALL equal the addressed word sampled at the completing cycle.
REQ-011 pslverr and prdata SHALL be 0 whenever pready=0.
REQ-012 A write SHALL take effect at the end of the completing cycle, updating only the bytes whose pwstrb bit is 1.
REQ-013 A write with pwstrb=0 SHALL complete without error and change nothing.
REQ-014 A prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; the cycle in which it equals TICK_DIV-1 is a tick.
REQ-015 mtime SHALL increment by 1 on each tick, modulo 2^64, so 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-016 The carry from mtime[31:0] into [63:32] SHALL occur in the same cycle as the increment.
REQ-017 When an mtime write completes in a tick cycle, the written bytes SHALL take the written value, the unwritten bytes SHALL keep their old value, and no increment SHALL be applied that cycle.
REQ-018 A write to mtime SHALL NOT reset the prescaler.
REQ-019 mtip SHALL be registered: mtip(n+1) = (mtime(n) >= mtimecmp(n)), an unsigned 64-bit compare of register values after cycle n's updates.
REQ-020 A write that sets mtimecmp above mtime SHALL therefore clear mtip one cycle after the write takes effect.
REQ-021 mtip SHALL depend on no APB signal except through register contents.

Reset
REQ-022 While rst=1, the block SHALL set mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, prescaler=0, FSM idle, mtip=0, pready=0, prdata=0, and pslverr=0.
REQ-023 An in-flight transfer SHALL be abandoned under reset with no register update.
REQ-024 When rst=1 coincides with a completing write, reset SHALL win.
REQ-025 The first tick after reset release SHALL occur TICK_DIV cycles after rst falls.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
 - TICK_DIV=1, reset, then read 0xBFF8 at idle -> prdata equals the elapsed cycle count; 2-cycle access with pready low then high; pslverr=0.
 - Write mtimecmp=0x0000_0000_0000_0020 via 0x4004=0 then 0x4000=0x20 -> mtip rises exactly one cycle after mtime reaches 0x20; writing 0x4000=0xFFFF_FFFF clears mtip one cycle after that write completes.
 - Write 0xBFF8=0xFFFF_FFFF, 0xBFFC=0xFFFF_FFFF -> after the next tick, mtime=0 and mtimecmp (reset value) compare drops mtip to 0.
 - Write 0xBFF8 with pwstrb=4'b0010, pwdata=0x0000_AB00 coinciding with a tick -> byte1=0xAB, other bytes unchanged, no increment that cycle.
 - Access at 0x0000 and at 0x4002 -> pslverr=1, prdata=0, all registers unchanged.
 - TICK_DIV=4, assert rst for 1 cycle mid-transfer -> no pready for the abandoned transfer; mtime=0 and first increment 4 cycles after release.
